// File: rtl/grf_scoreboard.sv
// Register-file write scoreboard: counts outstanding writes per register and
// gates decode issue on source readiness, destination depth and total capacity.
module grf_scoreboard #(
    parameter int MAX_PENDING  = 3,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic        issue_rs_used,
    input  logic        issue_rt_used,
    input  logic        issue_wr,
    input  logic [4:0]  issue_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    output logic [31:0] busy_mask,
    output logic [3:0]  inflight,
    output logic        err
);

    localparam logic [1:0] MAX_P = MAX_PENDING[1:0];
    localparam logic [3:0] MAX_I = MAX_INFLIGHT[3:0];

    logic [1:0]  cnt     [32];
    logic [1:0]  cnt_nxt [32];
    logic [31:0] busy_nxt;
    logic [31:0] up_vec;
    logic [31:0] dn_vec;
    logic [3:0]  inflight_nxt;

    logic [1:0]  rs_cnt;
    logic [1:0]  rt_cnt;
    logic [1:0]  rd_cnt;
    logic [1:0]  wb_cnt;
    logic        rs_hazard;
    logic        rt_hazard;
    logic        dst_stall;
    logic        cap_stall;
    logic        retire;
    logic        bad_wb;
    logic        inc;

    assign rs_cnt = cnt[issue_rs];
    assign rt_cnt = cnt[issue_rt];
    assign rd_cnt = cnt[issue_rd];
    assign wb_cnt = cnt[wb_reg];

    assign retire = wb_valid && (wb_reg != 5'd0) && (wb_cnt != 2'd0);
    assign bad_wb = wb_valid && (wb_reg != 5'd0) && (wb_cnt == 2'd0);

    // A source whose last pending write lands this cycle is read via write-through.
    assign rs_hazard = issue_rs_used && (issue_rs != 5'd0) && (rs_cnt != 2'd0)
                       && !(wb_valid && (wb_reg == issue_rs) && (rs_cnt == 2'd1));
    assign rt_hazard = issue_rt_used && (issue_rt != 5'd0) && (rt_cnt != 2'd0)
                       && !(wb_valid && (wb_reg == issue_rt) && (rt_cnt == 2'd1));

    assign dst_stall = issue_wr && (issue_rd != 5'd0) && (rd_cnt == MAX_P)
                       && !(wb_valid && (wb_reg == issue_rd));
    assign cap_stall = issue_wr && (issue_rd != 5'd0) && (inflight == MAX_I) && !retire;

    assign issue_ready = !flush && !rs_hazard && !rt_hazard && !dst_stall && !cap_stall;

    assign inc    = issue_valid && issue_ready && issue_wr && (issue_rd != 5'd0);
    assign up_vec = inc    ? (32'd1 << issue_rd) : 32'd0;
    assign dn_vec = retire ? (32'd1 << wb_reg)   : 32'd0;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_nxt[i] = cnt[i];
            if (up_vec[i] && !dn_vec[i]) begin
                cnt_nxt[i] = cnt[i] + 2'd1;
            end else if (dn_vec[i] && !up_vec[i]) begin
                cnt_nxt[i] = cnt[i] - 2'd1;
            end
            busy_nxt[i] = (cnt_nxt[i] != 2'd0);
        end
        cnt_nxt[0]  = 2'd0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        inflight_nxt = inflight;
        if (inc && !retire) begin
            inflight_nxt = inflight + 4'd1;
        end else if (retire && !inc) begin
            inflight_nxt = inflight - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= 2'd0;
            end
            busy_mask <= 32'd0;
            inflight  <= 4'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            busy_mask <= busy_nxt;
            inflight  <= inflight_nxt;
        end
    end

    // Sticky until reset; a flushed cycle performs no writeback check.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (!flush && bad_wb) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard with a per-cycle reference model check.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_rs_used;
    logic        issue_rt_used;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] busy_mask;
    logic [3:0]  inflight;
    logic        err;

    grf_scoreboard #(.MAX_PENDING(3), .MAX_INFLIGHT(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_wr(issue_wr), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .busy_mask(busy_mask), .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Reference state: plain integer pending counts per register.
    int cnt_m [32];
    int infl_m = 0;
    bit err_m  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_blocked(input bit used, input int r);
        if (!used || r == 0 || cnt_m[r] == 0) return 1'b0;
        if (wb_valid && int'(wb_reg) == r && cnt_m[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        int rd;
        bit wb_retires;
        rd = int'(issue_rd);
        wb_retires = wb_valid && wb_reg != 0 && cnt_m[wb_reg] > 0;
        if (flush) return 1'b0;
        if (src_blocked(issue_rs_used, int'(issue_rs))) return 1'b0;
        if (src_blocked(issue_rt_used, int'(issue_rt))) return 1'b0;
        if (issue_wr && rd != 0 && cnt_m[rd] == 3 && !(wb_valid && int'(wb_reg) == rd)) return 1'b0;
        if (issue_wr && rd != 0 && infl_m == 8 && !wb_retires) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = (cnt_m[i] > 0);
        return b;
    endfunction

    initial for (int i = 0; i < 32; i++) cnt_m[i] = 0;

    always @(posedge clk) begin
        bit fire;
        bit ret;
        bit bad;
        if (reset) begin
            for (int i = 0; i < 32; i++) cnt_m[i] = 0;
            infl_m = 0;
            err_m  = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) cnt_m[i] = 0;
            infl_m = 0;
        end else begin
            fire = issue_valid && m_ready();
            ret  = wb_valid && wb_reg != 0 && cnt_m[wb_reg] > 0;
            bad  = wb_valid && wb_reg != 0 && cnt_m[wb_reg] == 0;
            if (bad) err_m = 1'b1;
            if (ret) begin
                cnt_m[wb_reg] = cnt_m[wb_reg] - 1;
                infl_m = infl_m - 1;
            end
            if (fire && issue_wr && issue_rd != 0) begin
                cnt_m[issue_rd] = cnt_m[issue_rd] + 1;
                infl_m = infl_m + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_issue_ready", {31'd0, issue_ready}, {31'd0, m_ready()});
            chk("model_busy_mask", busy_mask, m_busy());
            chk("model_inflight", {28'd0, inflight}, 32'(infl_m));
            chk("model_err", {31'd0, err}, {31'd0, err_m});
        end
    end

    task automatic idle();
        flush = 0; issue_valid = 0; issue_rs = 0; issue_rt = 0;
        issue_rs_used = 0; issue_rt_used = 0; issue_wr = 0; issue_rd = 0;
        wb_valid = 0; wb_reg = 0;
    endtask

    task automatic set_issue(input logic [4:0] rs, input bit rs_u, input logic [4:0] rt,
                             input bit rt_u, input bit wr, input logic [4:0] rd);
        issue_valid = 1; issue_rs = rs; issue_rs_used = rs_u;
        issue_rt = rt; issue_rt_used = rt_u; issue_wr = wr; issue_rd = rd;
    endtask

    task automatic set_wb(input logic [4:0] r);
        wb_valid = 1; wb_reg = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        check_en = 1'b1;
        cyc();
        probe();
        chk("reset_busy", busy_mask, 32'd0);
        chk("reset_inflight", {28'd0, inflight}, 32'd0);
        chk("reset_ready", {31'd0, issue_ready}, 32'd1);
        chk("reset_err", {31'd0, err}, 32'd0);

        // Producer/consumer on $8 with write-through on writeback.
        set_issue(0, 0, 0, 0, 1, 8);
        cyc();
        set_issue(8, 1, 0, 0, 0, 0);
        probe();
        chk("raw_busy8", {31'd0, busy_mask[8]}, 32'd1);
        chk("raw_stall", {31'd0, issue_ready}, 32'd0);
        cyc();
        set_wb(8);
        probe();
        chk("raw_writethrough", {31'd0, issue_ready}, 32'd1);
        cyc();
        idle();
        probe();
        chk("raw_busy8_clear", {31'd0, busy_mask[8]}, 32'd0);

        // Two pending writes to $7: write-through only covers the last one.
        set_issue(0, 0, 0, 0, 1, 7);
        cyc(); cyc();
        set_issue(0, 0, 7, 1, 0, 0);
        set_wb(7);
        probe();
        chk("rt_cnt2_stall", {31'd0, issue_ready}, 32'd0);
        cyc();
        probe();
        chk("rt_cnt1_wt", {31'd0, issue_ready}, 32'd1);
        cyc();
        idle();

        // Per-register depth limit on $5.
        set_issue(0, 0, 0, 0, 1, 5);
        cyc(); cyc(); cyc();
        probe();
        chk("dst_full_stall", {31'd0, issue_ready}, 32'd0);
        set_wb(5);
        #1;
        chk("dst_full_wb_ok", {31'd0, issue_ready}, 32'd1);
        cyc();
        wb_valid = 0;
        probe();
        chk("dst_inflight3", {28'd0, inflight}, 32'd3);
        chk("dst_still_full", {31'd0, issue_ready}, 32'd0);
        issue_valid = 0;
        set_wb(5);
        cyc(); cyc(); cyc();
        idle();
        probe();
        chk("dst_drained", {28'd0, inflight}, 32'd0);

        // Global capacity: writes to $1..$8.
        for (int r = 1; r <= 8; r++) begin
            set_issue(0, 0, 0, 0, 1, 5'(r));
            cyc();
        end
        set_issue(0, 0, 0, 0, 1, 9);
        probe();
        chk("cap_inflight8", {28'd0, inflight}, 32'd8);
        chk("cap_stall", {31'd0, issue_ready}, 32'd0);
        set_wb(1);
        #1;
        chk("cap_relief_wb", {31'd0, issue_ready}, 32'd1);
        cyc();
        wb_valid = 0;
        set_issue(0, 0, 0, 0, 1, 0);
        probe();
        chk("cap_rd0_ready", {31'd0, issue_ready}, 32'd1);
        cyc();
        probe();
        chk("cap_rd0_inflight", {28'd0, inflight}, 32'd8);

        // Flush beats a simultaneous issue.
        set_issue(0, 0, 0, 0, 1, 6);
        flush = 1;
        probe();
        chk("flush_ready", {31'd0, issue_ready}, 32'd0);
        cyc();
        idle();
        probe();
        chk("flush_busy", busy_mask, 32'd0);
        chk("flush_inflight", {28'd0, inflight}, 32'd0);

        // Error flag behaviour.
        set_wb(9);
        flush = 1;
        cyc();
        idle();
        set_wb(0);
        cyc();
        idle();
        probe();
        chk("err_flush_wb_r0", {31'd0, err}, 32'd0);
        set_wb(9);
        cyc();
        idle();
        probe();
        chk("err_set", {31'd0, err}, 32'd1);
        flush = 1;
        cyc();
        idle();
        probe();
        chk("err_survives_flush", {31'd0, err}, 32'd1);
        reset = 1;
        cyc();
        reset = 0;
        probe();
        chk("err_reset", {31'd0, err}, 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
